cache_ctrl_2way: RTL and testbench
==================================

Name: cache_ctrl_2way

Overview:
- FSM controller sequencing the 2-way set-associative cache datapath: 8 indices, 128-bit lines, 16-bit byte addresses.
- Address split: tag [15:7], index [6:4], offset [3:0].
- Sits between the CPU memory port and physical memory. Write-back, write-allocate.
- Owns the per-index LRU state, chooses the victim way, and drives the set load strobes, write-type selects and the physical-memory handshake.

Parameters:
NUM_INDICES, 8, number of indices (LRU bit per index); index width = log2(NUM_INDICES) = 3
TAG_W, 9, tag width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_address  in  16  CPU byte address, stable while request held
mem_resp  out  1  CPU request complete (one-cycle pulse)
pmem_read  out  1  line fill request to physical memory
pmem_write  out  1  line writeback request to physical memory
pmem_resp  in  1  physical memory transaction complete
pmem_address  out  16  line-aligned physical address, [3:0]=0
hit, set_one_hit, set_two_hit  in  1 each  tag compare results from datapath
set_one_valid, set_two_valid  in  1 each  valid bits at current index
set_one_dirty, set_two_dirty  in  1 each  dirty bits at current index
set_one_tag, set_two_tag  in  TAG_W each  stored tags at current index
load_set_one, load_set_two  out  1 each  write strobe into way one / way two
write_type_set_one, write_type_set_two  out  1 each  1 = CPU write merge (sets dirty); 0 = line fill (clears dirty, sets valid)
wb_sel  out  1  selects which way's line drives pmem write data: 0 = way one, 1 = way two

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset is synchronous and active-high.
  - Reset: state=IDLE, all LRU bits=0, victim register=0.
  - All outputs 0 in the cycle after reset is sampled.
  - Reset mid-transaction aborts it: pmem_read/pmem_write drop the next cycle and no load strobe fires.
- Request and LRU rules:
  - mem_read && mem_write asserted together: treated as write.
  - LRU encoding: lru[idx]=0 means way one is least recent; lru[idx]=1 means way two is least recent.
  - Any hit served, or fill completed, updates lru[idx] to point at the other way.
- IDLE (compare):
  - Combinational outputs; hit decides within the same cycle.
  - Read hit: mem_resp=1 in the same cycle (0 wait states); lru[idx] updated at the edge.
  - Write hit: load strobe of the hit way =1, its write_type=1, mem_resp=1 in the same cycle; lru updated.
  - Miss (request && !hit), victim selection, in priority order:
    - way one if !set_one_valid;
    - else way two if !set_two_valid;
    - else lru[idx].
  - On a miss: victim latched at the edge, mem_resp=0.
  - Next state: WRITEBACK if the victim is valid and dirty, else FILL.
  - No request: all outputs 0, state unchanged.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim_tag, idx, 4'b0}, wb_sel=victim.
  - Held until pmem_resp; on pmem_resp -> FILL.
  - No load strobes in this state.
- FILL:
  - pmem_read=1, pmem_address={mem_address[15:4], 4'b0}.
  - On pmem_resp: load strobe of the victim way =1 with write_type=0 in that cycle; lru[idx] updated; -> IDLE.
  - The request then hits on the following cycle and is served as above.
- Latency:
  - Clean miss: 1 + N_fill + 1 cycles to mem_resp.
  - Dirty miss: adds N_wb cycles.
- Request dropped mid-miss: the current pmem transaction still completes and the line is still installed; no mem_resp.
- pmem_resp outside WRITEBACK/FILL: ignored.
- pmem_read and pmem_write are never asserted together.
- Load strobes are never asserted for both ways in one cycle.

Test Plan:
- Reset with all lines invalid; read 0x1234 (idx 3) -> FILL: pmem_read=1, pmem_address=0x1230; after pmem_resp, load_set_one=1 with write_type_set_one=0; the next cycle hits and mem_resp=1; lru[3]=1.
- Read 0x1234, then read 0x5234 (same idx 3, tag differs) -> fills way two; read 0x1234 again -> hit in way one, 0 wait states, lru[3]=1.
- Write 0x1234 hit -> load_set_one=1, write_type_set_one=1, mem_resp=1 in the same cycle. Then read 0x5234 (way two hit, lru[3]=0). Then read 0x9234 -> WRITEBACK with pmem_address=0x1230 and wb_sel=0, followed by FILL of 0x9230 into way one.
- Clean full set, lru[5]=1, read miss 0xA050 -> no writeback; victim way two; pmem_address=0xA050.
- Assert reset while pmem_write=1 in WRITEBACK -> the next cycle pmem_write=0, state IDLE, all lru=0, no load strobe.
- Drop mem_read during FILL -> the line is still installed on pmem_resp; mem_resp stays 0; IDLE follows.

Source files
------------

// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way: control FSM for a 2-way set-associative, write-back,
// write-allocate cache. 16-bit byte addresses, 128-bit lines, 8 indices.
// Address split: tag [15:7], index [6:4], offset [3:0].
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   mem_read, mem_write           CPU request (both high = write), held until mem_resp
//   mem_address                   CPU byte address
//   mem_resp                      one-cycle completion pulse to the CPU
//   pmem_read, pmem_write         line fill / line writeback request to physical memory
//   pmem_resp                     physical memory transaction complete
//   pmem_address                  line-aligned physical address
//   hit, set_one_hit, set_two_hit tag-compare results from the datapath
//   set_*_valid/_dirty/_tag       per-way line state at the current index
//   load_set_one, load_set_two    per-way write strobes
//   write_type_set_*              1 = CPU write merge (dirty), 0 = line fill (clean)
//   wb_sel                        way driving writeback data (0 = way one, 1 = way two)
module cache_ctrl_2way #(
  parameter int unsigned NUM_INDICES = 8,
  parameter int unsigned TAG_W       = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_address,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [15:0]      pmem_address,
  input  logic             hit,
  input  logic             set_one_hit,
  input  logic             set_two_hit,
  input  logic             set_one_valid,
  input  logic             set_two_valid,
  input  logic             set_one_dirty,
  input  logic             set_two_dirty,
  input  logic [TAG_W-1:0] set_one_tag,
  input  logic [TAG_W-1:0] set_two_tag,
  output logic             load_set_one,
  output logic             load_set_two,
  output logic             write_type_set_one,
  output logic             write_type_set_two,
  output logic             wb_sel
);

  localparam int unsigned IdxW = $clog2(NUM_INDICES);

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e                 state_q, state_d;
  logic [NUM_INDICES-1:0] lru_q, lru_d;    // 1 = way two is least recently used
  logic                   victim_q, victim_d;

  logic [IdxW-1:0] idx;
  logic            req;
  logic            is_write;
  logic            miss_victim;
  logic            victim_dirty;
  logic            unused_offset;

  assign idx           = mem_address[IdxW+3:4];
  assign req           = mem_read | mem_write;
  assign is_write      = mem_write;
  assign unused_offset = ^mem_address[3:0];

  // Invalid ways are filled first; only a full set consults LRU.
  always_comb begin
    miss_victim = 1'b0;
    if (!set_one_valid) begin
      miss_victim = 1'b0;
    end else if (!set_two_valid) begin
      miss_victim = 1'b1;
    end else begin
      miss_victim = lru_q[idx];
    end
    victim_dirty = miss_victim ? (set_two_valid & set_two_dirty)
                               : (set_one_valid & set_one_dirty);
  end

  always_comb begin
    state_d            = state_q;
    lru_d              = lru_q;
    victim_d           = victim_q;
    mem_resp           = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    pmem_address       = '0;
    load_set_one       = 1'b0;
    load_set_two       = 1'b0;
    write_type_set_one = 1'b0;
    write_type_set_two = 1'b0;
    wb_sel             = 1'b0;

    // Outputs are held quiet while reset is sampled so an aborted
    // transaction cannot fire a load strobe on the reset edge.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
              if (set_one_hit) begin
                load_set_one       = is_write;
                write_type_set_one = is_write;
                lru_d[idx]         = 1'b1;
              end else if (set_two_hit) begin
                load_set_two       = is_write;
                write_type_set_two = is_write;
                lru_d[idx]         = 1'b0;
              end
            end else begin
              victim_d = miss_victim;
              state_d  = victim_dirty ? StWriteback : StFill;
            end
          end
        end
        StWriteback: begin
          pmem_write   = 1'b1;
          pmem_address = {(victim_q ? set_two_tag : set_one_tag), idx, 4'b0000};
          wb_sel       = victim_q;
          if (pmem_resp) begin
            state_d = StFill;
          end
        end
        StFill: begin
          pmem_read    = 1'b1;
          pmem_address = {mem_address[15:4], 4'b0000};
          if (pmem_resp) begin
            load_set_one = ~victim_q;
            load_set_two = victim_q;
            lru_d[idx]   = ~victim_q;
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way. A small array-based datapath
// answers the tag compares; a transaction-level cache model predicts every
// output cycle; a single compare process checks them at the falling edge.
module tb_cache_ctrl_2way;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic        mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [15:0] pmem_address;
  logic        hit, set_one_hit, set_two_hit;
  logic        set_one_valid, set_two_valid, set_one_dirty, set_two_dirty;
  logic [8:0]  set_one_tag, set_two_tag;
  logic        load_set_one, load_set_two, write_type_set_one, write_type_set_two, wb_sel;

  always #5 clk = ~clk;

  cache_ctrl_2way #(.NUM_INDICES(8), .TAG_W(9)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .pmem_address(pmem_address),
    .hit(hit), .set_one_hit(set_one_hit), .set_two_hit(set_two_hit),
    .set_one_valid(set_one_valid), .set_two_valid(set_two_valid),
    .set_one_dirty(set_one_dirty), .set_two_dirty(set_two_dirty),
    .set_one_tag(set_one_tag), .set_two_tag(set_two_tag),
    .load_set_one(load_set_one), .load_set_two(load_set_two),
    .write_type_set_one(write_type_set_one), .write_type_set_two(write_type_set_two),
    .wb_sel(wb_sel)
  );

  // ---------------- datapath stand-in (reacts to the DUT strobes) ----------------
  logic       dp_clear;
  logic       dp_valid [2][8];
  logic       dp_dirty [2][8];
  logic [8:0] dp_tag   [2][8];
  logic [2:0] a_idx;
  logic [8:0] a_tag;

  assign a_idx         = mem_address[6:4];
  assign a_tag         = mem_address[15:7];
  assign set_one_valid = dp_valid[0][a_idx];
  assign set_two_valid = dp_valid[1][a_idx];
  assign set_one_dirty = dp_dirty[0][a_idx];
  assign set_two_dirty = dp_dirty[1][a_idx];
  assign set_one_tag   = dp_tag[0][a_idx];
  assign set_two_tag   = dp_tag[1][a_idx];
  assign set_one_hit   = dp_valid[0][a_idx] && (dp_tag[0][a_idx] == a_tag);
  assign set_two_hit   = dp_valid[1][a_idx] && (dp_tag[1][a_idx] == a_tag);
  assign hit           = set_one_hit | set_two_hit;

  always @(posedge clk) begin
    if (dp_clear) begin
      for (int w = 0; w < 2; w++) begin
        for (int i = 0; i < 8; i++) begin
          dp_valid[w][i] <= 1'b0;
          dp_dirty[w][i] <= 1'b0;
          dp_tag[w][i]   <= 9'h0;
        end
      end
    end else begin
      if (load_set_one) begin
        dp_valid[0][a_idx] <= 1'b1;
        dp_tag[0][a_idx]   <= a_tag;
        dp_dirty[0][a_idx] <= write_type_set_one;
      end
      if (load_set_two) begin
        dp_valid[1][a_idx] <= 1'b1;
        dp_tag[1][a_idx]   <= a_tag;
        dp_dirty[1][a_idx] <= write_type_set_two;
      end
    end
  end

  // ---------------- reference cache model ----------------
  logic       ref_valid [2][8];
  logic       ref_dirty [2][8];
  logic [8:0] ref_tag   [2][8];
  logic       ref_lru   [8];   // index of the least recently used way

  // ---------------- expectations handed to the compare process ----------------
  logic        exp_valid, exp_resp, exp_pr, exp_pw, exp_l1, exp_l2, exp_w1, exp_w2, exp_wbs;
  logic [15:0] exp_addr;
  int          txn_id;
  int          lit_sel;
  logic [15:0] lit_exp;

  int checks = 0;
  int errors = 0;

  int          seen_txn = -1;
  int          obs_cyc, obs_lat, obs_resp_cnt;
  logic        obs_wb_seen, obs_wb_sel;
  logic [15:0] obs_wb_addr, obs_fill_addr;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (txn_id != seen_txn) begin
      seen_txn      = txn_id;
      obs_cyc       = 0;
      obs_lat       = 0;
      obs_resp_cnt  = 0;
      obs_wb_seen   = 1'b0;
      obs_wb_sel    = 1'b0;
      obs_wb_addr   = 16'h0;
      obs_fill_addr = 16'h0;
    end
    if (exp_valid) begin
      chk("mem_resp",     16'(mem_resp),           16'(exp_resp));
      chk("pmem_read",    16'(pmem_read),          16'(exp_pr));
      chk("pmem_write",   16'(pmem_write),         16'(exp_pw));
      chk("pmem_address", pmem_address,            exp_addr);
      chk("load_set_one", 16'(load_set_one),       16'(exp_l1));
      chk("load_set_two", 16'(load_set_two),       16'(exp_l2));
      chk("wt_set_one",   16'(write_type_set_one), 16'(exp_w1));
      chk("wt_set_two",   16'(write_type_set_two), 16'(exp_w2));
      chk("wb_sel",       16'(wb_sel),             16'(exp_wbs));
      obs_cyc++;
      if (mem_resp) begin
        obs_resp_cnt++;
        if (obs_lat == 0) obs_lat = obs_cyc;
      end
      if (pmem_write) begin
        obs_wb_seen = 1'b1;
        obs_wb_addr = pmem_address;
        obs_wb_sel  = wb_sel;
      end
      if (pmem_read) obs_fill_addr = pmem_address;
    end
    case (lit_sel)
      1: chk("lit_fill_addr",  obs_fill_addr,        lit_exp);
      2: chk("lit_wb_addr",    obs_wb_addr,          lit_exp);
      3: chk("lit_wb_sel",     16'(obs_wb_sel),      lit_exp);
      4: chk("lit_latency",    16'(obs_lat),         lit_exp);
      5: chk("lit_resp_count", 16'(obs_resp_cnt),    lit_exp);
      6: chk("lit_wb_seen",    16'(obs_wb_seen),     lit_exp);
      default: begin
        if (lit_sel >= 10 && lit_sel < 18)
          chk($sformatf("lit_model_lru%0d", lit_sel - 10), 16'(ref_lru[lit_sel-10]), lit_exp);
      end
    endcase
  end

  // ---------------- driver helpers ----------------
  task automatic cyc(input logic resp, input logic pr, input logic pw, input logic [15:0] ad,
                     input logic l1, input logic l2, input logic w1, input logic w2,
                     input logic wbs);
    exp_valid = 1'b1;
    exp_resp  = resp;
    exp_pr    = pr;
    exp_pw    = pw;
    exp_addr  = ad;
    exp_l1    = l1;
    exp_l2    = l2;
    exp_w1    = w1;
    exp_w2    = w2;
    exp_wbs   = wbs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit(input int sel, input logic [15:0] e);
    exp_valid = 1'b0;
    lit_sel   = sel;
    lit_exp   = e;
    @(negedge clk);
    #1;
    lit_sel = 0;
    @(posedge clk);
    #1;
  endtask

  // One CPU request. drop_at: cycle index (from 1) at which the request is
  // withdrawn; rst_at: writeback beat at which reset is asserted (-1 = never).
  task automatic do_req(input logic [15:0] a, input logic rd, input logic wr, input int n_wb,
                        input int n_fill, input int drop_at, input int rst_at);
    logic [2:0] ix;
    logic [8:0] tg;
    int         hw, v, k;
    bit         held;
    ix = a[6:4];
    tg = a[15:7];
    txn_id++;
    mem_address = a;
    mem_read    = rd;
    mem_write   = wr;
    pmem_resp   = 1'($urandom_range(0, 1));
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (ref_valid[w][ix] && ref_tag[w][ix] == tg) hw = w;
    if (hw < 0) begin
      if (!ref_valid[0][ix]) v = 0;
      else if (!ref_valid[1][ix]) v = 1;
      else v = int'(ref_lru[ix]);
      idle_cyc();
      held = 1'b1;
      k    = 1;
      if (ref_valid[v][ix] && ref_dirty[v][ix]) begin
        for (int i = 0; i < n_wb; i++) begin
          if (k == drop_at) begin mem_read = 1'b0; mem_write = 1'b0; held = 1'b0; end
          if (i == rst_at) begin
            reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
            exp_valid = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int j = 0; j < 8; j++) ref_lru[j] = 1'b0;
            idle_cyc();
            return;
          end
          pmem_resp = (i == n_wb - 1);
          cyc(1'b0, 1'b0, 1'b1, {ref_tag[v][ix], ix, 4'h0}, 1'b0, 1'b0, 1'b0, 1'b0, v[0]);
          k++;
        end
      end
      for (int i = 0; i < n_fill; i++) begin
        if (k == drop_at) begin mem_read = 1'b0; mem_write = 1'b0; held = 1'b0; end
        pmem_resp = (i == n_fill - 1);
        cyc(1'b0, 1'b1, 1'b0, {a[15:4], 4'h0}, (i == n_fill - 1) && (v == 0),
            (i == n_fill - 1) && (v == 1), 1'b0, 1'b0, 1'b0);
        k++;
      end
      ref_valid[v][ix] = 1'b1;
      ref_tag[v][ix]   = tg;
      ref_dirty[v][ix] = 1'b0;
      ref_lru[ix]      = (v == 0);
      pmem_resp        = 1'($urandom_range(0, 1));
      if (held) hw = v;
      else idle_cyc();
    end
    if (hw >= 0) begin
      cyc(1'b1, 1'b0, 1'b0, 16'h0, wr && (hw == 0), wr && (hw == 1),
          wr && (hw == 0), wr && (hw == 1), 1'b0);
      ref_lru[ix] = (hw == 0);
      if (wr) ref_dirty[hw][ix] = 1'b1;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [8:0] tag_pool [4];

  initial begin
    int nwb, nf, drop, rq, nid;
    logic [15:0] ra;
    exp_valid = 1'b0; lit_sel = 0; lit_exp = 16'h0; txn_id = 0;
    reset = 1'b1; dp_clear = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0; pmem_resp = 1'b0;
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 8; i++) begin
        ref_valid[w][i] = 1'b0; ref_dirty[w][i] = 1'b0; ref_tag[w][i] = 9'h0;
      end
    for (int i = 0; i < 8; i++) ref_lru[i] = 1'b0;
    tag_pool[0] = 9'h024; tag_pool[1] = 9'h0a4; tag_pool[2] = 9'h124; tag_pool[3] = 9'h1ff;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; dp_clear = 1'b0;
    idle_cyc();

    // Cold read miss into way one.
    do_req(16'h1234, 1'b1, 1'b0, 0, 3, -1, -1);
    lit(1, 16'h1230); lit(4, 16'd5); lit(13, 16'd1);
    // Second tag fills way two, then way one hits with zero wait states.
    do_req(16'h5234, 1'b1, 1'b0, 0, 2, -1, -1);
    lit(13, 16'd0);
    do_req(16'h1234, 1'b1, 1'b0, 0, 1, -1, -1);
    lit(4, 16'd1); lit(13, 16'd1);
    // Write hit dirties way one; way two hit; third tag evicts dirty way one.
    do_req(16'h1234, 1'b0, 1'b1, 0, 1, -1, -1);
    lit(4, 16'd1);
    do_req(16'h5234, 1'b1, 1'b0, 0, 1, -1, -1);
    lit(13, 16'd0);
    do_req(16'h9234, 1'b1, 1'b0, 2, 2, -1, -1);
    lit(2, 16'h1230); lit(3, 16'd0); lit(1, 16'h9230); lit(4, 16'd6);
    // Clean full set at index 5 with way two least recent.
    do_req(16'h0050, 1'b1, 1'b0, 0, 1, -1, -1);
    do_req(16'h1050, 1'b1, 1'b0, 0, 1, -1, -1);
    do_req(16'h0050, 1'b1, 1'b0, 0, 1, -1, -1);
    lit(15, 16'd1);
    do_req(16'hA050, 1'b1, 1'b0, 3, 2, -1, -1);
    lit(6, 16'd0); lit(1, 16'hA050); lit(4, 16'd4); lit(15, 16'd0);
    // Reset during writeback at index 6; index 3 LRU must then be cleared.
    do_req(16'h2064, 1'b0, 1'b1, 0, 2, -1, -1);
    do_req(16'h3064, 1'b0, 1'b1, 0, 2, -1, -1);
    do_req(16'h4064, 1'b1, 1'b0, 3, 2, -1, 1);
    do_req(16'h1234, 1'b1, 1'b0, 0, 2, -1, -1);
    lit(13, 16'd1);
    do_req(16'h4064, 1'b1, 1'b0, 2, 2, -1, -1);
    lit(2, 16'h2060); lit(4, 16'd6);
    // Request withdrawn during the fill: line still installed, no response.
    do_req(16'h7010, 1'b1, 1'b0, 0, 3, 2, -1);
    lit(5, 16'd0);
    do_req(16'h7010, 1'b1, 1'b0, 0, 1, -1, -1);
    lit(4, 16'd1);

    // Randomized traffic over a small tag pool to force evictions.
    for (int n = 0; n < 300; n++) begin
      nid = $urandom_range(0, 2);
      for (int j = 0; j < nid; j++) begin
        mem_address = 16'($urandom);
        pmem_resp   = 1'($urandom_range(0, 1));
        idle_cyc();
      end
      ra   = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom)};
      rq   = $urandom_range(0, 2);
      nwb  = $urandom_range(1, 4);
      nf   = $urandom_range(1, 4);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, nf + 1) : -1;
      do_req(ra, rq != 1, rq != 0, nwb, nf, drop, -1);
    end
    pmem_resp = 1'b0;
    idle_cyc();
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
